dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h01000000, lowest valid data-memory byte address.
REQ-002 SHALL have parameter MEM_BYTES, default 32'h00100000, size of the valid data-memory window in bytes.
REQ-003 SHALL have port clock  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for each requester x in {0,1}: req_x in 1 (request), rw_x in 1 (1=write), size_x in 2 (0 byte, 1 half, 2 word), un_x in 1 (unsigned load), addr_x in 32, wdata_x in 32.
REQ-006 SHALL have, for each requester x: gnt_x out 1 (accepted), rvalid_x out 1 (response), rdata_x out 32 (load data), err_x out 1 (access rejected).
REQ-007 SHALL have memory-side ports mem_address out 32, mem_read_write out 1, mem_access_size out 2, mem_load_un out 1, mem_data_in out 32, mem_data_out in 32, matching dmemory port semantics.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-009 IDLE: at a rising edge with any req_x high, SHALL latch the winner's rw/size/un/addr/wdata and go to ACCESS; with no request, SHALL stay in IDLE.
REQ-010 ACCESS lasts exactly one cycle: gnt_x of the winner high; mem_* driven from latched values; for a write, mem_read_write=1 only in this cycle.
REQ-011 At the ACCESS-exit edge SHALL register mem_data_out into rdata_x and go to RESP.
REQ-012 RESP lasts exactly one cycle: rvalid_x=1 for the winner (loads and stores); rdata_x=0 for stores; then IDLE.
REQ-013 Requester SHALL hold req_x and its fields stable until gnt_x; the arbiter SHALL tolerate req_x dropping in RESP.
REQ-014 Latency: request sampled at edge E0 -> gnt_x in cycle E0..E1 -> rvalid_x in cycle E1..E2; throughput one access per 3 cycles.
REQ-015 Error check at latch: size_x=3, size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or addr outside [START_ADDR, START_ADDR+MEM_BYTES-4] -> error flagged.
REQ-016 Errored access: SHALL pass through ACCESS with mem_read_write=0 (no write), then RESP with err_x=1, rvalid_x=1, rdata_x=0.
REQ-017 Outside ACCESS, mem_read_write SHALL be 0; mem_address, mem_access_size, mem_load_un and mem_data_in SHALL hold their last values.
REQ-018 Only one gnt_x, one rvalid_x and one err_x SHALL ever be high per cycle; err_x SHALL never be high without rvalid_x.
REQ-019 Address comparison SHALL be 32-bit unsigned with no wrap-around: START_ADDR+MEM_BYTES overflow is treated as out of range.

Reset
REQ-020 reset_n=0 SHALL immediately force state IDLE and gnt_x, rvalid_x, err_x, mem_read_write to 0, and rdata_x, mem_address, mem_data_in, mem_access_size, mem_load_un to 0, regardless of clock.
REQ-021 Reset asserted during ACCESS SHALL abort the transaction (no write committed after reset assertion, no rvalid_x issued).
REQ-022 Round-robin pointer SHALL reset to "port 0 has priority".

Configuration
REQ-023 With DMEM_ARB_RR_EN defined: round-robin; on a simultaneous request, the port not granted last wins; pointer updates on every grant.
REQ-024 Without DMEM_ARB_RR_EN: fixed priority; port 0 always wins simultaneous requests; no pointer state.

Verification
REQ-025 Port 0 word write 0x000055D4 @0x01000000, then byte load un=1 -> rdata0=0x000000D4; un=0 half load -> 0x000055D4; un=0 byte load -> 0xFFFFFFD4.
REQ-026 After reset, req0 and req1 held high together (RR_EN) -> grants 0,1,0,1 every 3 cycles; without the macro -> grants 0,0,0, port 1 never granted.
REQ-027 Port 1 half write @0x01000001 -> mem_read_write stays 0, err1=1, rvalid1=1, rdata1=0; a subsequent word read @0x01000000 returns the unchanged value.
REQ-028 Port 0 word read @0x00FFFFFC and @0x010FFFFD -> err0=1 both; word read @0x010FFFFC -> err0=0.
REQ-029 reset_n pulled low mid-ACCESS of a word write 0xDEADBEEF -> all outputs 0 the same cycle, no rvalid; a read after reset does not return 0xDEADBEEF.
REQ-030 Store to port 1 while port 0 idle -> gnt1 for one cycle, rvalid1 one cycle later, rdata1=0, err1=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one access per three cycles (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter logic [31:0] START_ADDR = 32'h01000000,
    parameter logic [31:0] MEM_BYTES  = 32'h00100000
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        req_0,
    input  logic        rw_0,
    input  logic [1:0]  size_0,
    input  logic        un_0,
    input  logic [31:0] addr_0,
    input  logic [31:0] wdata_0,
    output logic        gnt_0,
    output logic        rvalid_0,
    output logic [31:0] rdata_0,
    output logic        err_0,

    input  logic        req_1,
    input  logic        rw_1,
    input  logic [1:0]  size_1,
    input  logic        un_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    output logic        gnt_1,
    output logic        rvalid_1,
    output logic [31:0] rdata_1,
    output logic        err_1,

    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_load_un,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Evaluated in 33 bits so a window reaching the top of the address space cannot wrap.
    localparam logic [32:0] WINDOW_END = {1'b0, START_ADDR} + {1'b0, MEM_BYTES};

    state_t      state;
    state_t      state_next;
    logic        winner;
    logic        lat_rw;
    logic        lat_err;

    logic        any_req;
    logic        sel;
    logic        sel_rw;
    logic [1:0]  sel_size;
    logic        sel_un;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [32:0] sel_addr_end;
    logic        sel_err;
    logic [31:0] load_data;

`ifdef DMEM_ARB_RR_EN
    logic        rr_ptr;

    always_comb begin
        sel = 1'b0;
        if (req_0 && req_1) begin
            sel = rr_ptr;
        end else begin
            sel = req_1;
        end
    end

    // rr_ptr names the port that wins the next tie; it flips away from every granted port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && any_req) begin
            rr_ptr <= ~sel;
        end
    end
`else
    always_comb begin
        sel = 1'b0;
        if (!req_0) begin
            sel = req_1;
        end
    end
`endif

    always_comb begin
        any_req   = req_0 || req_1;
        sel_rw    = sel ? rw_1    : rw_0;
        sel_size  = sel ? size_1  : size_0;
        sel_un    = sel ? un_1    : un_0;
        sel_addr  = sel ? addr_1  : addr_0;
        sel_wdata = sel ? wdata_1 : wdata_0;

        sel_addr_end = {1'b0, sel_addr} + 33'd4;
        sel_err      = 1'b0;
        case (sel_size)
            2'd0:    sel_err = 1'b0;
            2'd1:    sel_err = sel_addr[0];
            2'd2:    sel_err = |sel_addr[1:0];
            default: sel_err = 1'b1;
        endcase
        if (sel_addr < START_ADDR || sel_addr_end > WINDOW_END) begin
            sel_err = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        gnt_0          = 1'b0;
        gnt_1          = 1'b0;
        rvalid_0       = 1'b0;
        rvalid_1       = 1'b0;
        err_0          = 1'b0;
        err_1          = 1'b0;
        mem_read_write = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                gnt_0          = ~winner;
                gnt_1          = winner;
                mem_read_write = lat_rw && !lat_err;
                state_next     = RESP;
            end
            RESP: begin
                rvalid_0   = ~winner;
                rvalid_1   = winner;
                err_0      = ~winner && lat_err;
                err_1      = winner && lat_err;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_data = (lat_rw || lat_err) ? 32'd0 : mem_data_out;

    // Memory-side fields are loaded only at the latch edge, so they hold between accesses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            winner          <= 1'b0;
            lat_rw          <= 1'b0;
            lat_err         <= 1'b0;
            mem_address     <= 32'd0;
            mem_access_size <= 2'd0;
            mem_load_un     <= 1'b0;
            mem_data_in     <= 32'd0;
            rdata_0         <= 32'd0;
            rdata_1         <= 32'd0;
        end else begin
            if (state == IDLE && any_req) begin
                winner          <= sel;
                lat_rw          <= sel_rw;
                lat_err         <= sel_err;
                mem_address     <= sel_addr;
                mem_access_size <= sel_size;
                mem_load_un     <= sel_un;
                mem_data_in     <= sel_wdata;
            end
            if (state == ACCESS) begin
                if (winner) begin
                    rdata_1 <= load_data;
                end else begin
                    rdata_0 <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array memory stub and a reference model.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam logic [31:0] START = 32'h01000000;
    localparam logic [31:0] BYTES = 32'h00100000;

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        un;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_0, rw_0, un_0, req_1, rw_1, un_1;
    logic [1:0]  size_0, size_1;
    logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
    logic        gnt_0, rvalid_0, err_0, gnt_1, rvalid_1, err_1;
    logic [31:0] rdata_0, rdata_1;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write, mem_load_un;
    logic [1:0]  mem_access_size;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit [7:0]    ref_mem[logic [31:0]];
    bit [7:0]    stub_mem[logic [31:0]];
    bit          prev_gnt_0 = 1'b0;
    bit          prev_gnt_1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
    bit          ref_ptr = 1'b0;
`endif

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req_0(req_0), .rw_0(rw_0), .size_0(size_0), .un_0(un_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0), .err_0(err_0),
        .req_1(req_1), .rw_1(rw_1), .size_1(size_1), .un_1(un_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1), .err_1(err_1),
        .mem_address(mem_address), .mem_read_write(mem_read_write), .mem_access_size(mem_access_size),
        .mem_load_un(mem_load_un), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    function automatic void check_output(string name, logic [31:0] actual, logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endfunction

    function automatic logic [7:0] get_byte(bit use_ref, logic [31:0] a);
        if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
        return stub_mem.exists(a) ? stub_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] read_mem(bit use_ref, logic [31:0] a, logic [1:0] size, logic un);
        logic [31:0] raw;
        raw = {get_byte(use_ref, a + 3), get_byte(use_ref, a + 2), get_byte(use_ref, a + 1), get_byte(use_ref, a)};
        if (size == 2'd0) return un ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
        if (size == 2'd1) return un ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        return raw;
    endfunction

    function automatic void write_mem(bit use_ref, logic [31:0] a, logic [1:0] size, logic [31:0] d);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            if (use_ref) ref_mem[a + i] = d[8*i +: 8];
            else stub_mem[a + i] = d[8*i +: 8];
        end
    endfunction

    // Rejection rules computed in 64-bit arithmetic, so no wrap-around is possible.
    function automatic bit is_err(txn_t t);
        longint a, lo, hi;
        a  = t.addr;
        lo = START;
        hi = longint'(START) + longint'(BYTES);
        if (t.size == 2'd3) return 1'b1;
        if (t.size == 2'd1 && t.addr[0]) return 1'b1;
        if (t.size == 2'd2 && t.addr[1:0] != 2'd0) return 1'b1;
        return (a < lo) || (a + 4 > hi);
    endfunction

    function automatic exp_t model_txn(bit port, txn_t t);
        exp_t e;
        e.port = port;
        e.err  = is_err(t);
        e.data = 32'd0;
        if (!e.err) begin
            if (t.rw) write_mem(1'b1, t.addr, t.size, t.wdata);
            else e.data = read_mem(1'b1, t.addr, t.size, t.un);
        end
        return e;
    endfunction

    function automatic txn_t mk(logic rw, logic [1:0] size, logic un, logic [31:0] addr, logic [31:0] wdata);
        txn_t t;
        t.rw = rw; t.size = size; t.un = un; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int region;
        t.rw    = 1'($urandom_range(0, 1));
        t.un    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        region  = $urandom_range(0, 9);
        if (region < 6) t.addr = START + ($urandom_range(0, 15) << 2) + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
        else if (region < 8) t.addr = START + BYTES - 16 + $urandom_range(0, 15);
        else if (region < 9) t.addr = START - 8 + $urandom_range(0, 7);
        else t.addr = 32'hFFFFFFF8 + $urandom_range(0, 7);
        return t;
    endfunction

    // Environment memory: combinational-style read presented before each rising edge, write at the edge.
    always @(posedge clock) begin
        if (mem_read_write) write_mem(1'b0, mem_address, mem_access_size, mem_data_in);
    end

    always @(negedge clock) begin
        mem_data_out = read_mem(1'b0, mem_address, mem_access_size, mem_load_un);
    end

    // Monitor: structural invariants, gnt->rvalid latency, and scoreboard pop on every response.
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset_n) begin
            prev_gnt_0 = 1'b0;
            prev_gnt_1 = 1'b0;
        end else begin
            check_output("invariants",
                         {27'd0, gnt_0 && gnt_1, rvalid_0 && rvalid_1, err_0 && !rvalid_0,
                          err_1 && !rvalid_1, mem_read_write && !(gnt_0 || gnt_1)}, 32'd0);
            if (prev_gnt_0 || rvalid_0) check_output("latency_0", {30'd0, rvalid_0, gnt_0}, {30'd0, prev_gnt_0, 1'b0});
            if (prev_gnt_1 || rvalid_1) check_output("latency_1", {30'd0, rvalid_1, gnt_1}, {30'd0, prev_gnt_1, 1'b0});
            if (rvalid_0 || rvalid_1) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_rvalid", {31'd0, rvalid_1}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_output("resp_port", {31'd0, rvalid_1}, {31'd0, e.port});
                    check_output("resp_err", {31'd0, rvalid_1 ? err_1 : err_0}, {31'd0, e.err});
                    check_output("resp_data", rvalid_1 ? rdata_1 : rdata_0, e.data);
                end
            end
            prev_gnt_0 = gnt_0;
            prev_gnt_1 = gnt_1;
        end
    end

    task automatic check_reset_outputs(string tag);
        check_output({tag, "_ctrl"}, {23'd0, gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1,
                                      mem_read_write, mem_access_size, mem_load_un}, 32'd0);
        check_output({tag, "_rdata0"}, rdata_0, 32'd0);
        check_output({tag, "_rdata1"}, rdata_1, 32'd0);
        check_output({tag, "_maddr"}, mem_address, 32'd0);
        check_output({tag, "_mdin"}, mem_data_in, 32'd0);
    endtask

    task automatic set_fields(bit port, txn_t t);
        if (port) begin
            rw_1 = t.rw; size_1 = t.size; un_1 = t.un; addr_1 = t.addr; wdata_1 = t.wdata; req_1 = 1'b1;
        end else begin
            rw_0 = t.rw; size_0 = t.size; un_0 = t.un; addr_0 = t.addr; wdata_0 = t.wdata; req_0 = 1'b1;
        end
    endtask

    // Raise the chosen requests and drop each one as soon as its grant is seen.
    task automatic apply_stimulus(bit use_0, bit use_1, txn_t t0, txn_t t1);
        bit pend_0, pend_1;
        @(negedge clock);
        pend_0 = use_0;
        pend_1 = use_1;
        if (use_0) set_fields(1'b0, t0);
        if (use_1) set_fields(1'b1, t1);
        for (int i = 0; i < 40 && (pend_0 || pend_1); i++) begin
            @(negedge clock);
            #2;
            if (pend_0 && gnt_0) begin req_0 = 1'b0; pend_0 = 1'b0; end
            if (pend_1 && gnt_1) begin req_1 = 1'b0; pend_1 = 1'b0; end
        end
        if (pend_0 || pend_1) begin
            check_output("grant_timeout", {30'd0, pend_1, pend_0}, 32'd0);
            req_0 = 1'b0;
            req_1 = 1'b0;
        end
    endtask

    task automatic issue_model(bit use_0, bit use_1, txn_t t0, txn_t t1);
        bit first;
        if (use_0 && use_1) begin
`ifdef DMEM_ARB_RR_EN
            first = ref_ptr;
`else
            first = 1'b0;
`endif
            exp_q.push_back(model_txn(first, first ? t1 : t0));
            exp_q.push_back(model_txn(!first, first ? t0 : t1));
`ifdef DMEM_ARB_RR_EN
            ref_ptr = first;
`endif
        end else begin
            exp_q.push_back(model_txn(use_1, use_1 ? t1 : t0));
`ifdef DMEM_ARB_RR_EN
            ref_ptr = !use_1;
`endif
        end
        apply_stimulus(use_0, use_1, t0, t1);
    endtask

    task automatic issue_const(bit port, txn_t t, bit exp_err, logic [31:0] exp_data);
        exp_t e;
        void'(model_txn(port, t));
        e.port = port; e.err = exp_err; e.data = exp_data;
        exp_q.push_back(e);
`ifdef DMEM_ARB_RR_EN
        ref_ptr = !port;
`endif
        apply_stimulus(!port, port, t, t);
    endtask

    initial begin
        exp_t e;
        int grants;
        reset_n = 1'b0;
        {req_0, rw_0, un_0, req_1, rw_1, un_1} = '0;
        {size_0, size_1} = '0;
        {addr_0, wdata_0, addr_1, wdata_1} = '0;
        #1;
        check_reset_outputs("reset_start");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        issue_const(1'b0, mk(1'b1, 2'd2, 1'b0, START, 32'h000055D4), 1'b0, 32'h0);
        issue_const(1'b0, mk(1'b0, 2'd0, 1'b1, START, 32'h0), 1'b0, 32'h000000D4);
        issue_const(1'b0, mk(1'b0, 2'd1, 1'b0, START, 32'h0), 1'b0, 32'h000055D4);
        issue_const(1'b0, mk(1'b0, 2'd0, 1'b0, START, 32'h0), 1'b0, 32'hFFFFFFD4);

        issue_const(1'b1, mk(1'b1, 2'd1, 1'b0, START + 1, 32'h1234ABCD), 1'b1, 32'h0);
        issue_const(1'b1, mk(1'b0, 2'd2, 1'b0, START, 32'h0), 1'b0, 32'h000055D4);

        issue_const(1'b0, mk(1'b0, 2'd2, 1'b0, 32'h00FFFFFC, 32'h0), 1'b1, 32'h0);
        issue_const(1'b0, mk(1'b0, 2'd2, 1'b0, 32'h010FFFFD, 32'h0), 1'b1, 32'h0);
        issue_const(1'b0, mk(1'b0, 2'd2, 1'b0, 32'h010FFFFC, 32'h0), 1'b0, 32'h0);
        issue_const(1'b0, mk(1'b0, 2'd3, 1'b0, START, 32'h0), 1'b1, 32'h0);

        issue_const(1'b1, mk(1'b1, 2'd2, 1'b0, START + 32'h10, 32'hCAFEF00D), 1'b0, 32'h0);
        issue_const(1'b0, mk(1'b0, 2'd2, 1'b0, START + 32'h10, 32'h0), 1'b0, 32'hCAFEF00D);

        // Abort a write mid-ACCESS with reset; the old word must survive.
        issue_const(1'b0, mk(1'b1, 2'd2, 1'b0, START + 32'h20, 32'h11223344), 1'b0, 32'h0);
        @(negedge clock);
        set_fields(1'b0, mk(1'b1, 2'd2, 1'b0, START + 32'h20, 32'hDEADBEEF));
        for (int i = 0; i < 20 && !gnt_0; i++) begin
            @(negedge clock);
            #2;
        end
        check_output("abort_gnt_seen", {31'd0, gnt_0}, 32'd1);
        reset_n = 1'b0;
        req_0 = 1'b0;
        #1;
        check_reset_outputs("reset_abort");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
`ifdef DMEM_ARB_RR_EN
        ref_ptr = 1'b0;
`endif
        issue_const(1'b0, mk(1'b0, 2'd2, 1'b0, START + 32'h20, 32'h0), 1'b0, 32'h11223344);

        // Both ports request continuously from the reset pointer state; four grants.
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            e.port = 1'(i % 2);
`else
            e.port = 1'b0;
`endif
            e.err = 1'b0;
            e.data = 32'h000055D4;
            exp_q.push_back(e);
        end
        @(negedge clock);
        set_fields(1'b0, mk(1'b0, 2'd2, 1'b0, START, 32'h0));
        set_fields(1'b1, mk(1'b0, 2'd2, 1'b0, START, 32'h0));
        grants = 0;
        for (int i = 0; i < 60 && grants < 4; i++) begin
            @(negedge clock);
            #2;
            if (gnt_0 || gnt_1) grants++;
        end
        req_0 = 1'b0;
        req_1 = 1'b0;
        check_output("hold_grants", grants, 4);
`ifdef DMEM_ARB_RR_EN
        ref_ptr = 1'b0;
`endif

        for (int r = 0; r < 80; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            issue_model(mode != 1, mode != 0, rand_txn(), rand_txn());
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check_output("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
